// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin shared comparator: parameter defaults,
// FSM state encoding and the helper that sizes requester ids.
package alu_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 32;
  localparam int ID_W_DEF = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Width of a requester id; never zero so a single requester still gets a port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ALUComp.sv
// Team comparator primitive: unsigned W-bit greater-than.
module ALUComp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         gt_o
);

  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr_i,
// wrapping modulo NREQ. Grant is one-hot, or all-zero when nothing requests.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  always_comb begin
    logic found;
    // NOTE: every combinationally driven signal gets a default before any
    // conditional assignment, so no path leaves it unassigned and infers a latch.
    gnt_o = '0;
    found = 1'b0;
    // Upper segment [ptr..NREQ-1] has priority over the wrapped segment [0..ptr-1].
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i] && (i < int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_comp_sched.sv
// Shares one unsigned greater-than comparator among NREQ requesters with
// round-robin fairness: IDLE (arbitrate/accept) -> CMP (compare) -> RESP (hold result).
module alu_comp_sched
  import alu_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_y,
  input  logic [NREQ-1:0]   resp_ready,
  output logic              busy
);

  localparam int ID_W = id_width(NREQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [W-1:0]      y_q, y_d;

  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [W-1:0]      sel_a, sel_b;
  logic              cmp_gt;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  ALUComp #(.W(W)) u_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .gt_o (cmp_gt)
  );

  // One-hot grant to owner id and AND-OR operand select.
  always_comb begin
    gnt_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
      sel_a = sel_a | (req_a[i*W +: W] & {W{gnt[i]}});
      sel_b = sel_b | (req_b[i*W +: W] & {W{gnt[i]}});
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    y_d        = y_q;
    req_ready  = '0;
    resp_valid = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = gnt;
        if (|req_valid) begin
          state_d  = S_CMP;
          owner_d  = gnt_id;
          a_d      = sel_a;
          b_d      = sel_b;
          rr_ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
      end
      S_CMP: begin
        y_d     = W'(cmp_gt);
        state_d = S_RESP;
      end
      S_RESP: begin
        for (int i = 0; i < NREQ; i++) resp_valid[i] = (owner_q == ID_W'(i));
        if (resp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are silenced during a reset cycle so nothing is accepted or delivered.
    if (rst) begin
      req_ready  = '0;
      resp_valid = '0;
    end
    busy = !rst && (state_q != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      y_q      <= y_d;
    end
  end

  // NOTE: operand registers carry no reset; they are only consumed after an
  // acceptance has loaded them, so resetting them would cost logic for nothing.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign resp_y = y_q;

endmodule

// File: tb/tb_alu_comp_sched.sv
// Self-checking bench for alu_comp_sched: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a transaction-level reference model.
module tb_alu_comp_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready, resp_valid, resp_ready;
  logic [W-1:0]      resp_y;
  logic              busy;

  alu_comp_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: m_age counts cycles since acceptance (0 = no transaction).
  int         m_age, m_rr, m_owner;
  logic [W-1:0] m_a, m_b, m_y;
  bit         auto_drop = 1'b1;
  int         grants[$];
  int         grant_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  // One clock cycle: check outputs mid-cycle, advance the model, cross the edge.
  task automatic step();
    int g, dg;
    logic [NREQ-1:0] er, ev, acc;
    @(negedge clk);
    g  = pick(req_valid, m_rr);
    er = '0;
    ev = '0;
    if (!rst && m_age == 0 && g >= 0) er[g] = 1'b1;
    if (!rst && m_age >= 2) ev[m_owner] = 1'b1;
    check("req_ready",  64'(req_ready),  64'(er));
    check("resp_valid", 64'(resp_valid), 64'(ev));
    check("resp_y",     64'(resp_y),     64'(m_y));
    check("busy",       64'(busy),       64'(!rst && m_age != 0));

    acc = req_ready & req_valid;
    dg  = -1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) dg = i;
    if (dg >= 0) begin
      grants.push_back(dg);
      grant_cyc.push_back(cyc);
    end

    if (rst) begin
      m_age = 0; m_rr = 0; m_owner = 0; m_y = '0;
    end else if (m_age == 0) begin
      if (g >= 0) begin
        m_owner = g;
        m_a     = req_a[g*W +: W];
        m_b     = req_b[g*W +: W];
        m_rr    = (g + 1) % NREQ;
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
      m_y   = (m_a > m_b) ? W'(1) : W'(0);
    end else if (resp_ready[m_owner]) begin
      m_age = 0;
    end

    @(posedge clk);
    #1;
    cyc++;
    if (auto_drop && dg >= 0) req_valid[dg] = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((m_age != 0 || req_valid != '0) && budget < 40) begin
      step();
      budget++;
    end
    if (budget >= 40) check("drain_timeout", 64'(m_age), 64'(0));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = '0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '1;
    m_age = 0; m_rr = 0; m_owner = 0; m_y = '0; m_a = '0; m_b = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Single request with timing.
    set_req(0, W'(5), W'(3));
    repeat (4) step();
    drain();

    // Equality and extremes.
    set_req(1, W'(7), W'(7));      drain();
    set_req(2, '1, '0);            drain();
    set_req(3, '0, '1);            drain();

    // All requesters held valid from reset: fairness and throughput.
    do_reset(1);
    auto_drop = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, W'($urandom), W'($urandom));
    grants.delete();
    grant_cyc.delete();
    repeat (13) step();
    check("rr_grant_count", 64'(grants.size()), 64'(5));
    if (grants.size() >= 5) begin
      check("rr_order0", 64'(grants[0]), 64'(0));
      check("rr_order1", 64'(grants[1]), 64'(1));
      check("rr_order2", 64'(grants[2]), 64'(2));
      check("rr_order3", 64'(grants[3]), 64'(3));
      check("rr_order4", 64'(grants[4]), 64'(0));
      for (int i = 1; i < 5; i++)
        check("rr_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(3));
    end
    req_valid = '0;
    auto_drop = 1'b1;
    drain();

    // Backpressure with a non-owner acknowledging; a second requester waits.
    set_req(1, W'(9), W'(2));
    set_req(3, W'(1), W'(4));
    resp_ready = 4'b1101;
    repeat (7) step();
    resp_ready = '1;
    drain();

    // Reset during CMP aborts the operation; next grant favours requester 0.
    set_req(2, W'(1), W'(0));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, W'($urandom), W'($urandom));
    grants.delete();
    step();
    check("post_reset_grant_n", 64'(grants.size()), 64'(1));
    if (grants.size() >= 1) check("post_reset_grant", 64'(grants[0]), 64'(0));
    req_valid = '0;
    drain();

    // Pointer wrap: pointer at 3 with requests 1001.
    do_reset(1);
    set_req(2, W'(3), W'(3));
    drain();
    grants.delete();
    set_req(0, W'(2), W'(1));
    set_req(3, W'(8), W'(9));
    drain();
    check("wrap_grant_n", 64'(grants.size()), 64'(2));
    if (grants.size() >= 2) begin
      check("wrap_grant0", 64'(grants[0]), 64'(3));
      check("wrap_grant1", 64'(grants[1]), 64'(0));
    end

    // Randomized traffic with backpressure, drops and occasional reset.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          logic [W-1:0] a;
          a = rand_op();
          set_req(i, a, ($urandom_range(0, 4) == 0) ? a : rand_op());
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = NREQ'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = '1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_comp_sched.md
ALU_COMP_SCHED -- requirements
Module: alu_comp_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the comparator (2..8).
REQ-002 Parameter W, default 32, operand width.
REQ-003 Port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 Port rst, input, 1, synchronous, active-high reset.
REQ-005 Port req_valid, input, NREQ, per-requester request valid.
REQ-006 Port req_a, input, NREQ*W, packed operand A; slice i belongs to requester i.
REQ-007 Port req_b, input, NREQ*W, packed operand B; slice i belongs to requester i.
REQ-008 Port req_ready, output, NREQ, one-hot accept strobe to the granted requester.
REQ-009 Port resp_valid, output, NREQ, one-hot result valid toward the owning requester.
REQ-010 Port resp_y, output, W, comparison result: 1 if A>B unsigned, else 0; upper bits zero.
REQ-011 Port resp_ready, input, NREQ, per-requester result acceptance.
REQ-012 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 The block SHALL share one unsigned W-bit greater-than comparator among NREQ requesters with round-robin fairness.
REQ-014 FSM states SHALL be IDLE, CMP, RESP.
- IDLE -> CMP when any req_valid is high.
- CMP -> RESP unconditionally, after one cycle.
- RESP -> IDLE when resp_ready[owner] is high.
REQ-015 In IDLE, req_ready SHALL combinationally assert for exactly one requester: the first valid requester at or after rr_ptr, modulo NREQ.
REQ-016 A request SHALL be accepted in the cycle req_valid[i] & req_ready[i]; the owner id, A and B SHALL be registered in that cycle.
REQ-017 On acceptance, rr_ptr SHALL become (owner+1) mod NREQ.
REQ-018 In CMP, the comparator output on the registered operands SHALL be registered into resp_y.
REQ-019 resp_valid[owner] SHALL assert in RESP, exactly 2 cycles after the acceptance edge.
- resp_valid and resp_y SHALL hold stable until resp_ready[owner] is high.
REQ-020 resp_ready bits of non-owners SHALL be ignored.
REQ-021 req_ready SHALL be all-zero outside IDLE; requests arriving then SHALL wait, with no loss and no reordering of arbitration.
REQ-022 Back-to-back throughput SHALL be one result per 3 cycles when resp_ready is tied high.
REQ-023 Equal operands SHALL yield 0.
REQ-024 A=2^W-1 with B=0 SHALL yield 1; the comparison is unsigned, with no sign interpretation.
REQ-025 A requester dropping req_valid while not granted SHALL simply lose arbitration eligibility; this is not an error.

Reset
REQ-026 While rst is high at a clock edge:
- state=IDLE, rr_ptr=0, owner=0, resp_y=0;
- req_ready=0 and resp_valid=0 during that cycle;
- busy=0.
REQ-027 Reset asserted in CMP or RESP SHALL abort the in-flight operation; no resp_valid SHALL appear for it.
REQ-028 The first grant after reset SHALL favour requester 0.

Structure
REQ-029 State encoding enum, the NREQ/W defaults and the id width (clog2 NREQ) SHALL reside in the shared package alu_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).
REQ-031 The comparison SHALL use one instance of the team's ALUComp comparator.
REQ-032 No other arithmetic SHALL be instantiated.

Verification
REQ-033 Single request: req_valid=0001, A=5, B=3, resp_ready=1 -> req_ready=0001 at cycle 0, resp_valid=0001 with resp_y=1 at cycle 2, busy low at cycle 3.
REQ-034 Equality and extremes: (7,7) -> resp_y=0; (FFFFFFFF,0) -> 1; (0,FFFFFFFF) -> 0.
REQ-035 All four requesters held valid continuously from reset -> grant order 0,1,2,3,0; one result per 3 cycles.
REQ-036 Backpressure: resp_ready[owner]=0 for 5 cycles -> resp_valid and resp_y stable throughout, req_ready=0, and resp_ready of a non-owner ignored.
REQ-037 Reset mid-CMP: assert rst for 1 cycle -> no resp_valid, busy=0; the next grant goes to requester 0.
REQ-038 Pointer wrap: NREQ=4, rr_ptr=3, requests 1001 -> grant 1000, then 0001.
